// File: rtl/vga_scan_gen.sv
// Raster scan generator: walks horizontal/vertical timing and emits the packed display address,
// syncs, video-active and line/frame strobes. Optional frame counter under VGA_FRAME_COUNT_EN.
module vga_scan_gen #(
  parameter int unsigned H_VIS  = 800,
  parameter int unsigned H_FP   = 40,
  parameter int unsigned H_SYNC = 128,
  parameter int unsigned H_BP   = 88,
  parameter int unsigned V_VIS  = 600,
  parameter int unsigned V_FP   = 1,
  parameter int unsigned V_SYNC = 4,
  parameter int unsigned V_BP   = 23,
  parameter logic        HS_POL = 1'b1,
  parameter logic        VS_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  output logic [21:0] display_addr,
  output logic        video_active,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0]  frame_cnt
`endif
);

  localparam int unsigned CNT_W    = 11;
  // Totals must not exceed 2048 so the 11-bit counters can reach TOTAL-1.
  localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VIS + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VIS + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;
  logic             vis_c;
  logic             hs_on;
  logic             vs_on;
  logic             at_line;
  logic             at_origin;

  // Decode of the current counter position
  always_comb begin
    h_last    = (32'(h_cnt) == H_TOTAL - 1);
    v_last    = (32'(v_cnt) == V_TOTAL - 1);
    vis_c     = (32'(h_cnt) < H_VIS) && (32'(v_cnt) < V_VIS);
    hs_on     = (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END);
    vs_on     = (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END);
    at_line   = (h_cnt == '0);
    at_origin = at_line && (v_cnt == '0);
  end

  // Position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // Outputs present the position that was sampled on the ce cycle; strobes last one clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_addr <= '0;
      video_active <= 1'b0;
      hsync        <= ~HS_POL;
      vsync        <= ~VS_POL;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        display_addr <= {h_cnt, v_cnt};
        video_active <= vis_c;
        hsync        <= hs_on ? HS_POL : ~HS_POL;
        vsync        <= vs_on ? VS_POL : ~VS_POL;
        line_start   <= at_line;
        frame_start  <= at_origin;
      end
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic seen_frame;

  // The first frame after reset is frame 0; later frame starts count up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt  <= '0;
      seen_frame <= 1'b0;
    end else if (pix_ce && at_origin) begin
      if (seen_frame) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      seen_frame <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Raster scan generator: the producer side of the packed display address bus consumed by the image mapper.
- Walks the full horizontal and vertical timing (visible area plus blanking).
- Emits the packed display address {x[10:0], y[10:0]}, hsync, vsync, a video-active qualifier and frame/line strobes.
- Sits between the pixel clock domain and the image mapper / pixel ROM path.

Parameters:
- H_VIS, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_VIS, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- pix_ce  input  1  pixel clock enable; one pixel advance per clk where high
- display_addr  output  22  {x[10:0] in [21:11], y[10:0] in [10:0]} of the current pixel
- video_active  output  1  high when x < H_VIS and y < V_VIS
- hsync  output  1  horizontal sync, level per HS_POL
- vsync  output  1  vertical sync, level per VS_POL
- line_start  output  1  one-clk strobe when x == 0 is presented
- frame_start  output  1  one-clk strobe when x == 0 and y == 0 are presented

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Totals: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (628).
- Constraint: H_TOTAL, V_TOTAL <= 2048; out-of-range totals are a configuration error.
- Internal counters h_cnt, v_cnt, 11 bits each; reset value 0.
- Cycle with pix_ce=1:
  - Output registers load from the current (h_cnt, v_cnt).
  - Then h_cnt increments.
  - At h_cnt == H_TOTAL-1: h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt == V_TOTAL-1 during that wrap: v_cnt wraps to 0.
- Cycle with pix_ce=0: counters and all level outputs hold; line_start and frame_start are 0.
- Latency: outputs reflect a counter position one clk after the pix_ce cycle that sampled it.
- display_addr = {h_cnt, v_cnt}. Raw counters are driven in blanking too; no clamping. Downstream gates with video_active.
- hsync = HS_POL when H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC, else ~HS_POL.
- vsync = VS_POL when V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC, else ~VS_POL. vsync therefore changes only when the presented x == 0.
- line_start = 1 for exactly one clk when the loaded h_cnt == 0.
- frame_start = 1 for exactly one clk when the loaded h_cnt == 0 and v_cnt == 0.
- Reset values:
  - display_addr = 0, video_active = 0, line_start = 0, frame_start = 0.
  - hsync = ~HS_POL, vsync = ~VS_POL.
- First pix_ce after reset presents (0,0): video_active=1, line_start=1, frame_start=1.
- Reset mid-frame: counters and outputs return to reset values immediately (asynchronous); the scan restarts at (0,0) on the next pix_ce. No partial-line recovery.
- Continuous pix_ce=1: frame period is exactly H_TOTAL*V_TOTAL clks (663168 with defaults).

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- When defined:
  - Extra output frame_cnt [7:0], reset 0.
  - Increments by 1 in the same clk that frame_start is asserted, except the first frame_start after reset, which leaves it at 0.
  - Wraps 255 -> 0.
- When undefined: port absent and no counter logic; all other behaviour identical.

Test Plan:
- Reset release, pix_ce held 1 -> clk 1 after first ce: display_addr=22'h0, video_active=1, line_start=1, frame_start=1, hsync=0, vsync=0.
- Free-run one line -> presented x=799 has video_active=1; x=800 has video_active=0.
- Same line, hsync timing -> hsync=1 exactly for x=840..967 (128 clks); display_addr[21:11]=1055 then 0 with line_start=1 and y=1.
- Free-run one frame -> vsync=1 for y=601..604 (4 lines = 4224 clks); second frame_start exactly 663168 clks after the first.
- pix_ce toggled 1/0 alternately -> address advances once per two clks; line_start/frame_start never wider than one clk; levels hold during ce=0.
- Assert rst_n=0 at presented (500,300) -> outputs go to reset values without waiting for clk. VGA_FRAME_COUNT_EN build: after 3 full frames frame_cnt=3.
